// File: rtl/pong_score_bcd.sv
// Two-player PONG score keeper with BCD digit outputs and win detection.
// Optional LEADING_ZERO_BLANK_EN maps a zero tens digit to the blank code 4'hF.
module pong_score_bcd #(
  parameter int WIN_SCORE = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       point_l,
  input  logic       point_r,
  input  logic       new_game,
  output logic [3:0] l_ones,
  output logic [3:0] l_tens,
  output logic [3:0] r_ones,
  output logic [3:0] r_tens,
  output logic       game_over,
  output logic       winner
);

  localparam logic [6:0] WIN = 7'(WIN_SCORE);
  localparam logic [6:0] MAX = 7'd99;

  typedef enum logic {
    PLAY      = 1'b0,
    GAME_OVER = 1'b1
  } state_t;

  state_t     state_q, state_n;
  logic [3:0] l_ones_q, l_tens_q, r_ones_q, r_tens_q;
  logic [3:0] l_ones_n, l_tens_n, r_ones_n, r_tens_n;
  logic [6:0] l_cnt_q, r_cnt_q, l_cnt_n, r_cnt_n;
  logic       winner_q, winner_n;
  logic       point_l_q, point_r_q;
  logic       edge_l, edge_r;

  // Saturating two-digit BCD increment; 99 holds.
  function automatic logic [7:0] bcd_inc(input logic [7:0] d);
    logic [7:0] r;
    if (d == 8'h99)
      r = d;
    else if (d[3:0] == 4'd9)
      r = {d[7:4] + 4'd1, 4'd0};
    else
      r = {d[7:4], d[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [6:0] cnt_inc(input logic [6:0] c);
    return (c == MAX) ? c : c + 7'd1;
  endfunction

  assign edge_l = point_l & ~point_l_q;
  assign edge_r = point_r & ~point_r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PLAY;
      l_ones_q  <= '0;
      l_tens_q  <= '0;
      r_ones_q  <= '0;
      r_tens_q  <= '0;
      l_cnt_q   <= '0;
      r_cnt_q   <= '0;
      winner_q  <= 1'b0;
      point_l_q <= 1'b0;
      point_r_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      l_ones_q  <= l_ones_n;
      l_tens_q  <= l_tens_n;
      r_ones_q  <= r_ones_n;
      r_tens_q  <= r_tens_n;
      l_cnt_q   <= l_cnt_n;
      r_cnt_q   <= r_cnt_n;
      winner_q  <= winner_n;
      point_l_q <= point_l;
      point_r_q <= point_r;
    end
  end

  always_comb begin
    state_n  = state_q;
    l_ones_n = l_ones_q;
    l_tens_n = l_tens_q;
    r_ones_n = r_ones_q;
    r_tens_n = r_tens_q;
    l_cnt_n  = l_cnt_q;
    r_cnt_n  = r_cnt_q;
    winner_n = winner_q;
    if (new_game) begin
      state_n  = PLAY;
      l_ones_n = '0;
      l_tens_n = '0;
      r_ones_n = '0;
      r_tens_n = '0;
      l_cnt_n  = '0;
      r_cnt_n  = '0;
      winner_n = 1'b0;
    end else begin
      unique case (state_q)
        PLAY: begin
          // Simultaneous edges cancel each other out.
          if (edge_l && !edge_r) begin
            {l_tens_n, l_ones_n} = bcd_inc({l_tens_q, l_ones_q});
            l_cnt_n = cnt_inc(l_cnt_q);
            if (l_cnt_n == WIN) begin
              state_n  = GAME_OVER;
              winner_n = 1'b0;
            end
          end else if (edge_r && !edge_l) begin
            {r_tens_n, r_ones_n} = bcd_inc({r_tens_q, r_ones_q});
            r_cnt_n = cnt_inc(r_cnt_q);
            if (r_cnt_n == WIN) begin
              state_n  = GAME_OVER;
              winner_n = 1'b1;
            end
          end
        end
        GAME_OVER: begin
          state_n = GAME_OVER;
        end
        default: state_n = PLAY;
      endcase
    end
  end

  assign l_ones    = l_ones_q;
  assign r_ones    = r_ones_q;
  assign game_over = (state_q == GAME_OVER);
  assign winner    = winner_q;

`ifdef LEADING_ZERO_BLANK_EN
  assign l_tens = (l_tens_q == 4'd0) ? 4'hF : l_tens_q;
  assign r_tens = (r_tens_q == 4'd0) ? 4'hF : r_tens_q;
`else
  assign l_tens = l_tens_q;
  assign r_tens = r_tens_q;
`endif

endmodule
